mode_counter: RTL

- Parametrised, programmable successor to the team's fixed 4-bit free-running counter.
- Adds:
  - configurable width;
  - programmable terminal value;
  - four count modes (up, down, up/down bounce, one-shot);
  - a clock-enable prescaler;
  - synchronous clear and parallel load;
  - a terminal-count pulse and a one-shot done flag.
- Used as the general timer/event-counter primitive in the datapath and control blocks.

---
 rtl/mode_counter_pkg.sv | 19 +
 rtl/mode_counter_prescaler.sv | 31 +++
 rtl/mode_counter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mode_counter_pkg.sv
// Shared types for the programmable mode counter.
package mode_counter_pkg;

  // Count mode, encoded exactly as the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_UP_WRAP   = 2'b00,
    MODE_DOWN_WRAP = 2'b01,
    MODE_BOUNCE    = 2'b10,
    MODE_ONE_SHOT  = 2'b11
  } mode_e;

  // Counter FSM: direction of travel, or halted after a one-shot run.
  typedef enum logic [1:0] {
    S_UP   = 2'b00,
    S_DOWN = 2'b01,
    S_HALT = 2'b10
  } state_e;

endpackage

// File: rtl/mode_counter_prescaler.sv
// Clock-enable prescaler: one tick every prescale+1 enabled cycles.
module mode_counter_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_q, pre_d;

  // Tick on reaching the divide value; >= so that lowering prescale
  // mid-period ticks at once instead of running through a full wrap.
  always_comb begin
    tick  = enable && (pre_q >= prescale);
    pre_d = pre_q;
    if (clr)         pre_d = '0;
    else if (tick)   pre_d = '0;
    else if (enable) pre_d = pre_q + 1'b1;
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end

endmodule

// File: rtl/mode_counter.sv
// Programmable timer/event counter: up, down, bounce and one-shot modes
// with prescaler, synchronous clear, parallel load, tc pulse, done flag.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sync_clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      max_value,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  dir,
  output logic                  tc,
  output logic                  done
);

  mode_e            mode_i;
  state_e           state_q, state_d, eff_state;
  logic [WIDTH-1:0] count_q, count_d, step_val;
  logic             dir_q, dir_d, tc_q, tc_d, done_q, done_d;
  logic             tick, at_max, above_max;

  assign mode_i = mode_e'(mode);

  mode_counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .clr      (sync_clr | load),
    .prescale (prescale),
    .tick     (tick)
  );

  // Next count/state: clear beats load beats step; a mode change only
  // takes hold through eff_state at the next step.
  always_comb begin
    count_d   = count_q;
    state_d   = state_q;
    tc_d      = 1'b0;
    done_d    = done_q;
    step_val  = count_q;
    at_max    = (count_q >= max_value);
    above_max = (count_q > max_value);

    case (mode_i)
      MODE_UP_WRAP:   eff_state = S_UP;
      MODE_DOWN_WRAP: eff_state = S_DOWN;
      MODE_BOUNCE:    eff_state = (state_q == S_HALT) ? S_UP : state_q;
      MODE_ONE_SHOT:  eff_state = (state_q == S_HALT) ? S_HALT : S_UP;
      default:        eff_state = S_UP;
    endcase

    if (sync_clr) begin
      count_d = '0;
      done_d  = 1'b0;
      state_d = (mode_i == MODE_DOWN_WRAP) ? S_DOWN : S_UP;
    end else if (load) begin
      count_d = (load_value > max_value) ? max_value : load_value;
      done_d  = 1'b0;
      if (mode_i == MODE_DOWN_WRAP)   state_d = S_DOWN;
      else if (mode_i == MODE_BOUNCE) state_d = (state_q == S_DOWN) ? S_DOWN : S_UP;
      else                            state_d = S_UP;
    end else if (tick) begin
      case (mode_i)
        MODE_UP_WRAP: begin
          step_val = at_max ? '0 : count_q + 1'b1;
          tc_d     = (step_val == max_value);
          state_d  = S_UP;
        end
        MODE_DOWN_WRAP: begin
          step_val = (count_q == '0) ? max_value : count_q - 1'b1;
          tc_d     = (step_val == '0);
          state_d  = S_DOWN;
        end
        MODE_BOUNCE: begin
          if (above_max) begin
            // max was lowered under us: snap to it and turn around
            step_val = max_value;
            tc_d     = 1'b1;
            state_d  = S_DOWN;
          end else if (eff_state == S_UP) begin
            step_val = at_max ? max_value : count_q + 1'b1;
            tc_d     = (step_val == max_value);
            state_d  = tc_d ? S_DOWN : S_UP;
          end else begin
            step_val = (count_q == '0) ? '0 : count_q - 1'b1;
            tc_d     = (step_val == '0);
            state_d  = tc_d ? S_UP : S_DOWN;
          end
        end
        MODE_ONE_SHOT: begin
          if (eff_state == S_HALT) begin
            step_val = count_q;
            state_d  = S_HALT;
          end else begin
            step_val = at_max ? max_value : count_q + 1'b1;
            tc_d     = (step_val == max_value);
            state_d  = tc_d ? S_HALT : S_UP;
          end
        end
        default: begin
          step_val = count_q;
          state_d  = state_q;
        end
      endcase
      count_d = step_val;
      done_d  = (state_d == S_HALT);
    end

    dir_d = (state_d != S_DOWN);
  end

  // Registered count, FSM state and flag outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      state_q <= S_UP;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule
